wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Parametrised in-system trace capture for the 5-stage pipeline.
//  - Records every retired register write leaving WB (pc, dest reg, data) into a circular buffer.
//  - Three capture modes: continuous wrap, stop-when-full, and triggered with post-trigger count.
//  - Read port drains the buffer oldest-first once capture has stopped, replacing cycle-by-cycle
//    $display monitoring of WB.
// PARAMETERS
//  DATA_W  32               write-back data width
//  REG_W   5                register address width
//  PC_W    8                PC tag width
//  DEPTH   16               buffer entries; power of 2, >= 2
//  CNT_W   $clog2(DEPTH)+1  width of count and cfg_post
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  cap_valid     in   1       WB retiring a register write (RegWriteOut)
//  cap_pc        in   PC_W    PC of the retiring instruction
//  cap_reg       in   REG_W   destination register (WriteRegOut)
//  cap_data      in   DATA_W  write-back data (WriteData)
//  cfg_mode      in   2       00 wrap, 01 stop-full, 10 trigger, 11 = treated as 00
//  cfg_trig_reg  in   REG_W   trigger register address (mode 10)
//  cfg_post      in   CNT_W   captures after the trigger entry (mode 10)
//  arm           in   1       pulse: clear buffer, start capture
//  stop          in   1       pulse: end capture
//  rd_en         in   1       pop oldest entry
//  rd_valid      out  1       rd_* hold a valid entry
//  rd_pc         out  PC_W    oldest entry PC
//  rd_reg        out  REG_W   oldest entry register
//  rd_data       out  DATA_W  oldest entry data
//  count         out  CNT_W   entries held, 0..DEPTH
//  state         out  2       00 IDLE, 01 ARMED, 10 POST, 11 DONE
//  triggered     out  1       sticky; trigger matched since last arm
//  overflow      out  1       sticky; an entry was overwritten since last arm
// BEHAVIOUR
//  Reset
//  - rst=1: state=IDLE, pointers=0, count=0, triggered=0, overflow=0, post counter=0.
//  - Any rst mid-capture aborts immediately to these values. Stored RAM contents need not clear.
//  Capture qualifier
//  - cap_ok = cap_valid && cap_reg!=0. Writes to r0 are never recorded.
//  - A qualified capture is written on that clk edge; count/state reflect it next cycle.
//  IDLE
//  - No capture. arm -> ARMED.
//  ARMED
//  - Every cap_ok is stored at wr_ptr.
//  - Mode 00/11: when count==DEPTH the oldest entry is overwritten (rd_ptr advances, count holds)
//    and overflow is set.
//  - Mode 01: the capture that makes count==DEPTH moves state -> DONE. Nothing further is stored.
//  - Mode 10: wraps as in mode 00. A cap_ok with cap_reg==cfg_trig_reg is stored and sets triggered.
//    That entry moves state -> POST with post counter=cfg_post, or -> DONE if cfg_post==0.
//  POST
//  - Wrap capture continues; each cap_ok decrements the post counter.
//  - The capture that reaches 0 moves state -> DONE. Trigger matches in POST are ignored.
//  DONE
//  - No capture. arm -> ARMED.
//  stop and arm
//  - stop in ARMED/POST -> DONE; the capture on that same edge is still stored. stop is ignored
//    in IDLE/DONE.
//  - arm in any state clears pointers, count, triggered and overflow and goes to ARMED.
//    A cap_valid on the same edge is dropped. arm has priority over stop, rd_en and capture.
//  Readout
//  - rd_valid = (state==IDLE || state==DONE) && count!=0.
//  - rd_* are combinational from rd_ptr (show-ahead) and are 0 when rd_valid=0.
//  - rd_en && rd_valid: rd_ptr+1 mod DEPTH and count-1 on that edge.
//  - rd_en with rd_valid=0 is ignored, so there is no underflow and no popping while capturing.
//  Pointers
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. Full = count==DEPTH, empty = count==0.
// TESTING (DEPTH=16)
//  1 Mode 01: arm, 20 caps reg=1..20, data=i*3
//      -> DONE after 16th, count=16, overflow=0; 16 pops give reg 1..16, data 3..48; then rd_valid=0.
//  2 Mode 00: arm, 20 caps reg=i, then stop
//      -> count=16, overflow=1, state DONE; pops give reg 5..20 in order.
//  3 Mode 10, trig_reg=7, post=3: caps reg=1..12
//      -> triggered=1 at reg7, DONE after reg10, count=10; pops give 1..10.
//  4 Mode 10, post=0, trig_reg=2: caps reg=1,2,3 -> DONE on reg2, count=2, reg3 not stored.
//  5 cap_reg=0 caps ignored (count unchanged); arm with cap_valid in same cycle -> count=0, ARMED.
//  6 arm, 3 caps, rst pulse mid-stream
//      -> count=0, state=IDLE, flags 0, rd_valid=0; a subsequent arm captures normally.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular capture of retired WB register writes with wrap/stop-full/trigger modes
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int PC_W   = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_valid,
  input  logic [PC_W-1:0]   cap_pc,
  input  logic [REG_W-1:0]  cap_reg,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [1:0]        cfg_mode,
  input  logic [REG_W-1:0]  cfg_trig_reg,
  input  logic [CNT_W-1:0]  cfg_post,
  input  logic              arm,
  input  logic              stop,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [PC_W-1:0]   rd_pc,
  output logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_POST = 2'b10, S_DONE = 2'b11} state_t;
  state_t             r_state, w_state_n;
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, r_post, w_post_n;
  logic               r_trig, w_trig_n, r_ovf;
  logic [PC_W-1:0]    r_mem_pc   [DEPTH];
  logic [REG_W-1:0]   r_mem_reg  [DEPTH];
  logic [DATA_W-1:0]  r_mem_data [DEPTH];
  logic w_cap_ok, w_full, w_m_stop, w_m_trig, w_store, w_ovw, w_pop, w_trig_hit;
  assign w_cap_ok   = cap_valid && cap_reg != '0;
  assign w_full     = r_count == CNT_W'(DEPTH);
  assign w_m_stop   = cfg_mode == 2'b01;
  assign w_m_trig   = cfg_mode == 2'b10;
  assign w_store    = !arm && w_cap_ok &&
                      (r_state == S_POST || (r_state == S_ARMED && !(w_m_stop && w_full)));
  assign w_ovw      = w_store && w_full;
  assign w_pop      = !arm && rd_en && rd_valid;
  assign w_trig_hit = w_store && r_state == S_ARMED && w_m_trig && cap_reg == cfg_trig_reg;
  // Next state, post-trigger counter and trigger flag; arm overrides everything
  always_comb begin
    w_state_n = r_state;
    w_post_n  = r_post;
    w_trig_n  = r_trig;
    if (arm) begin
      w_state_n = S_ARMED;
      w_trig_n  = 1'b0;
    end else if (r_state == S_ARMED) begin
      if (w_store && w_m_stop && r_count == CNT_W'(DEPTH - 1)) w_state_n = S_DONE;
      if (w_trig_hit) begin
        w_trig_n  = 1'b1;
        w_post_n  = cfg_post;
        w_state_n = cfg_post == '0 ? S_DONE : S_POST;
      end
      if (stop) w_state_n = S_DONE;
    end else if (r_state == S_POST) begin
      if (w_store) begin
        w_post_n  = r_post - 1'b1;
        w_state_n = r_post == CNT_W'(1) ? S_DONE : S_POST;
      end
      if (stop) w_state_n = S_DONE;
    end
  end
  // State register and trigger bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_post  <= '0;
      r_trig  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_post  <= w_post_n;
      r_trig  <= w_trig_n;
    end
  end
  // Pointers, occupancy and overflow flag; an overwrite advances the read side and holds count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (arm) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_ovw || w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_ovw) r_ovf <= 1'b1;
      if (w_store && !w_ovw) r_count <= r_count + 1'b1;
      else if (w_pop) r_count <= r_count - 1'b1;
    end
  end
  // Trace storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_pc[r_wr_ptr]   <= cap_pc;
      r_mem_reg[r_wr_ptr]  <= cap_reg;
      r_mem_data[r_wr_ptr] <= cap_data;
    end
  end
  assign rd_valid  = (r_state == S_IDLE || r_state == S_DONE) && r_count != '0;
  assign rd_pc     = rd_valid ? r_mem_pc[r_rd_ptr] : '0;
  assign rd_reg    = rd_valid ? r_mem_reg[r_rd_ptr] : '0;
  assign rd_data   = rd_valid ? r_mem_data[r_rd_ptr] : '0;
  assign count     = r_count;
  assign state     = r_state;
  assign triggered = r_trig;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed checks of capture modes, triggering, readout and reset abort
module tb_wb_trace_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_valid = 1'b0;
  logic [7:0]  cap_pc = '0;
  logic [4:0]  cap_reg = '0;
  logic [31:0] cap_data = '0;
  logic [1:0]  cfg_mode = '0;
  logic [4:0]  cfg_trig_reg = '0;
  logic [4:0]  cfg_post = '0;
  logic        arm = 1'b0, stop = 1'b0, rd_en = 1'b0;
  logic        rd_valid, triggered, overflow;
  logic [7:0]  rd_pc;
  logic [4:0]  rd_reg, count;
  logic [31:0] rd_data;
  logic [1:0]  state;
  int n_tests = 0, n_fail = 0;
  wb_trace_buffer dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_reg(cap_reg),
    .cap_data(cap_data), .cfg_mode(cfg_mode), .cfg_trig_reg(cfg_trig_reg), .cfg_post(cfg_post),
    .arm(arm), .stop(stop), .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_reg(rd_reg),
    .rd_data(rd_data), .count(count), .state(state), .triggered(triggered), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cap(input int r, input int d);
    cap_valid = 1'b1;
    cap_reg   = 5'(r);
    cap_data  = 32'(d);
    cap_pc    = 8'(r + 8'h40);
    tick();
    cap_valid = 1'b0;
  endtask
  task automatic do_arm(input logic [1:0] m, input int tr, input int p);
    cfg_mode = m;
    cfg_trig_reg = 5'(tr);
    cfg_post = 5'(p);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input int r, input int d);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_reg"}, 32'(rd_reg), 32'(r));
    chk({tag, "_data"}, rd_data, 32'(d));
    chk({tag, "_pc"}, 32'(rd_pc), 32'(r + 8'h40));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask
  initial begin
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_flags", {30'd0, triggered, overflow}, 32'd0);
    rst = 1'b0;
    tick();
    // 1: stop-when-full
    do_arm(2'b01, 0, 0);
    chk("t1_armed", 32'(state), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      cap(i, i * 3);
      if (i == 15) chk("t1_state15", 32'(state), 32'd1);
      if (i == 16) chk("t1_state16", 32'(state), 32'd3);
    end
    chk("t1_count", 32'(count), 32'd16);
    chk("t1_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 16; i++) pop_chk("t1_pop", i, i * 3);
    chk("t1_empty_valid", 32'(rd_valid), 32'd0);
    chk("t1_empty_data", rd_data, 32'd0);
    chk("t1_empty_count", 32'(count), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t1_no_underflow", 32'(count), 32'd0);
    // 2: wrap then stop
    do_arm(2'b00, 0, 0);
    for (int i = 1; i <= 20; i++) cap(i, i + 100);
    chk("t2_armed", 32'(state), 32'd1);
    chk("t2_rd_valid_armed", 32'(rd_valid), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t2_no_pop_armed", 32'(count), 32'd16);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_done", 32'(state), 32'd3);
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 5; i <= 20; i++) pop_chk("t2_pop", i, i + 100);
    chk("t2_empty", 32'(rd_valid), 32'd0);
    // 3: trigger with post count 3
    do_arm(2'b10, 7, 3);
    for (int i = 1; i <= 12; i++) begin
      cap(i, i);
      if (i == 6) chk("t3_trig_before", 32'(triggered), 32'd0);
      if (i == 7) begin
        chk("t3_trig", 32'(triggered), 32'd1);
        chk("t3_post", 32'(state), 32'd2);
      end
      if (i == 9) chk("t3_post9", 32'(state), 32'd2);
      if (i == 10) chk("t3_done", 32'(state), 32'd3);
    end
    chk("t3_count", 32'(count), 32'd10);
    chk("t3_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 10; i++) pop_chk("t3_pop", i, i);
    // 4: trigger with post count 0
    do_arm(2'b10, 2, 0);
    chk("t4_trig_cleared", 32'(triggered), 32'd0);
    cap(1, 11);
    cap(2, 22);
    chk("t4_done", 32'(state), 32'd3);
    cap(3, 33);
    chk("t4_count", 32'(count), 32'd2);
    pop_chk("t4_pop", 1, 11);
    pop_chk("t4_pop", 2, 22);
    chk("t4_empty", 32'(rd_valid), 32'd0);
    // 5: r0 writes ignored; arm drops same-edge capture
    do_arm(2'b00, 0, 0);
    cap(0, 5);
    cap(0, 6);
    chk("t5_r0", 32'(count), 32'd0);
    cap(5, 7);
    chk("t5_one", 32'(count), 32'd1);
    arm = 1'b1;
    cap(6, 8);
    arm = 1'b0;
    chk("t5_arm_cap_count", 32'(count), 32'd0);
    chk("t5_arm_cap_state", 32'(state), 32'd1);
    // 6: reset mid-capture after a trigger
    do_arm(2'b10, 2, 5);
    cap(1, 1);
    cap(2, 2);
    cap(3, 3);
    chk("t6_pre_trig", 32'(triggered), 32'd1);
    chk("t6_pre_state", 32'(state), 32'd2);
    rst = 1'b1;
    #2;
    chk("t6_async_state", 32'(state), 32'd0);
    tick();
    rst = 1'b0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_flags", {30'd0, triggered, overflow}, 32'd0);
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    do_arm(2'b00, 0, 0);
    cap(9, 90);
    cap(10, 100);
    stop = 1'b1;
    cap(11, 110);
    stop = 1'b0;
    chk("t6_stop_done", 32'(state), 32'd3);
    chk("t6_count_after", 32'(count), 32'd3);
    pop_chk("t6_pop", 9, 90);
    pop_chk("t6_pop", 10, 100);
    pop_chk("t6_pop", 11, 110);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_stop_ignored", 32'(state), 32'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
